// File: rtl/updi_phy_responder.sv
// UPDI-style half-duplex PHY: 12-bit frames at one bit per clk, 4-deep RX FIFO.
// Define UPDI_BREAK_DET_EN to enable line-break detection (R_BREAK state).
module updi_phy_responder (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       err_clr,
  output logic       parity_err,
  output logic       frame_err,
  output logic       ovf_err,
  output logic       break_det
);

  localparam logic [2:0] R_IDLE  = 3'd0;
  localparam logic [2:0] R_DATA  = 3'd1;
  localparam logic [2:0] R_PAR   = 3'd2;
  localparam logic [2:0] R_STOP1 = 3'd3;
  localparam logic [2:0] R_STOP2 = 3'd4;
`ifdef UPDI_BREAK_DET_EN
  localparam logic [2:0] R_BREAK = 3'd5;
`endif

  localparam logic [0:0] T_IDLE  = 1'b0;
  localparam logic [0:0] T_SHIFT = 1'b1;

  logic [2:0]  r_rx_st;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_rx_sh;
  logic        r_par;
  logic        r_stop1;

  logic [0:0]  r_tx_st;
  logic [10:0] r_tx_sh;
  logic [3:0]  r_tx_cnt;
  logic        r_txd;

  logic [7:0]  r_mem [4];
  logic [1:0]  r_wp;
  logic [1:0]  r_rp;
  logic [2:0]  r_cnt;

  logic        r_perr;
  logic        r_ferr;
  logic        r_oerr;

  logic        w_brk;
  logic        w_lowrun;
  logic        w_pend_fire;
  logic        w_eval;
  logic        w_stop_bad;
  logic        w_par_bad;
  logic        w_good;
  logic        w_pop;
  logic        w_push;
  logic        w_ovf;
  logic        w_tx_go;

`ifdef UPDI_BREAK_DET_EN
  logic [4:0]  r_lo;
  logic        r_pend;
  logic        r_brk;

  assign w_brk = !rxd && (r_lo == 5'd23) && (r_rx_st != R_BREAK);
  // An all-low frame may be the front of a break; hold its error until rxd rises.
  assign w_lowrun    = (r_lo >= 5'd11) && !rxd;
  assign w_pend_fire = r_pend && rxd;
  assign break_det   = r_brk;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lo   <= 5'd0;
      r_pend <= 1'b0;
      r_brk  <= 1'b0;
    end else begin
      r_brk <= w_brk;
      if (rxd)
        r_lo <= 5'd0;
      else if (r_lo != 5'd24)
        r_lo <= r_lo + 5'd1;
      if (w_brk)
        r_pend <= 1'b0;
      else if (w_eval && w_stop_bad && w_lowrun)
        r_pend <= 1'b1;
      else if (rxd)
        r_pend <= 1'b0;
    end
  end
`else
  assign w_brk       = 1'b0;
  assign w_lowrun    = 1'b0;
  assign w_pend_fire = 1'b0;
  assign break_det   = 1'b0;
`endif

  assign w_eval     = (r_rx_st == R_STOP2) && !w_brk;
  assign w_stop_bad = !r_stop1 || !rxd;
  assign w_par_bad  = r_par != ^r_rx_sh;
  assign w_good     = w_eval && !w_stop_bad && !w_par_bad;

  assign rx_valid = r_cnt != 3'd0;
  assign rx_data  = r_mem[r_rp];
  assign w_pop    = rx_ready && rx_valid;
  assign w_push   = w_good && ((r_cnt != 3'd4) || w_pop);
  assign w_ovf    = w_good && (r_cnt == 3'd4) && !w_pop;

  assign tx_ready = (r_tx_st == T_IDLE) && (r_rx_st == R_IDLE) && rxd;
  assign w_tx_go  = tx_valid && tx_ready;
  assign txd      = r_txd;

  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign ovf_err    = r_oerr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_st   <= R_IDLE;
      r_bit_cnt <= 3'd0;
      r_rx_sh   <= 8'd0;
      r_par     <= 1'b0;
      r_stop1   <= 1'b0;
    end else if (w_brk) begin
`ifdef UPDI_BREAK_DET_EN
      r_rx_st <= R_BREAK;
`endif
    end else begin
      case (r_rx_st)
        R_IDLE: begin
          if (!rxd && (r_tx_st == T_IDLE)) begin
            r_rx_st   <= R_DATA;
            r_bit_cnt <= 3'd0;
          end
        end
        R_DATA: begin
          r_rx_sh   <= {rxd, r_rx_sh[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7)
            r_rx_st <= R_PAR;
        end
        R_PAR: begin
          r_par   <= rxd;
          r_rx_st <= R_STOP1;
        end
        R_STOP1: begin
          r_stop1 <= rxd;
          r_rx_st <= R_STOP2;
        end
        R_STOP2: r_rx_st <= R_IDLE;
`ifdef UPDI_BREAK_DET_EN
        R_BREAK: if (rxd) r_rx_st <= R_IDLE;
`endif
        default: r_rx_st <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        r_mem[i] <= 8'd0;
      r_wp  <= 2'd0;
      r_rp  <= 2'd0;
      r_cnt <= 3'd0;
    end else if (w_brk) begin
      r_wp  <= 2'd0;
      r_rp  <= 2'd0;
      r_cnt <= 3'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= r_rx_sh;
        r_wp        <= r_wp + 2'd1;
      end
      if (w_pop)
        r_rp <= r_rp + 2'd1;
      r_cnt <= r_cnt + {2'b0, w_push} - {2'b0, w_pop};
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_oerr <= 1'b0;
    end else begin
      r_perr <= (w_eval && !w_stop_bad && w_par_bad) || (r_perr && !err_clr);
      r_ferr <= (w_eval && w_stop_bad && !w_lowrun) || w_pend_fire
                || (r_ferr && !err_clr);
      r_oerr <= w_ovf || (r_oerr && !err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_st  <= T_IDLE;
      r_tx_sh  <= 11'd0;
      r_tx_cnt <= 4'd0;
      r_txd    <= 1'b1;
    end else if (w_brk) begin
      r_tx_st <= T_IDLE;
      r_txd   <= 1'b1;
    end else begin
      case (r_tx_st)
        T_IDLE: begin
          if (w_tx_go) begin
            r_txd    <= 1'b0;
            r_tx_sh  <= {2'b11, ^tx_data, tx_data};
            r_tx_cnt <= 4'd0;
            r_tx_st  <= T_SHIFT;
          end
        end
        default: begin
          if (r_tx_cnt == 4'd11) begin
            r_txd   <= 1'b1;
            r_tx_st <= T_IDLE;
          end else begin
            r_txd    <= r_tx_sh[0];
            r_tx_sh  <= {1'b0, r_tx_sh[10:1]};
            r_tx_cnt <= r_tx_cnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule
